// File: rtl/mouse_pkg.sv
// mouse_pkg
//   Shared types and constants for the PS/2 mouse packet decoder.
//   - state_t      : packet assembly state (which byte is expected next)
//   - BIT_*        : bit positions of the fields inside packet byte 0
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    // Byte 0 layout: buttons, sync marker, delta sign bits, overflow bits.
    localparam int BIT_L    = 0;
    localparam int BIT_R    = 1;
    localparam int BIT_M    = 2;
    localparam int BIT_SYNC = 3;
    localparam int BIT_XS   = 4;
    localparam int BIT_YS   = 5;
    localparam int BIT_XV   = 6;
    localparam int BIT_YV   = 7;

endpackage

// File: rtl/mouse_axis_accum.sv
// mouse_axis_accum
//   Combinational next-position calculation for one cursor axis.
//   next_pos = clamp(pos +/- delta, 0, max_pos); the delta is ignored when
//   the overflow flag is set. INVERT=1 subtracts the delta, which is used
//   for Y because PS/2 reports +Y as up while the screen has 0 at the top.
// Ports:
//   pos      in  8  current position
//   delta    in  9  two's-complement movement {sign, magnitude byte}
//   ovf      in  1  overflow flag; forces the delta to zero
//   max_pos  in  8  upper clamp limit
//   next_pos out 8  clamped position to load at commit
module mouse_axis_accum #(
    parameter bit INVERT = 1'b0
) (
    input  logic [7:0] pos,
    input  logic [8:0] delta,
    input  logic       ovf,
    input  logic [7:0] max_pos,
    output logic [7:0] next_pos
);

    logic signed [9:0] d_ext;
    logic signed [9:0] sum;

    // 10 bits signed holds 0..255 +/- 256 without wrapping.
    // NOTE: every variable assigned in this block gets a value on every
    // path, otherwise synthesis infers a latch.
    always_comb begin
        d_ext = ovf ? 10'sd0 : $signed({delta[8], delta});
        if (INVERT) sum = $signed({2'b00, pos}) - d_ext;
        else        sum = $signed({2'b00, pos}) + d_ext;

        if (sum < 10'sd0)                          next_pos = 8'd0;
        else if (sum > $signed({2'b00, max_pos}))  next_pos = max_pos;
        else                                       next_pos = sum[7:0];
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder
//   Assembles 3-byte PS/2 stream-mode packets and keeps an absolute, clamped
//   cursor position plus the last status byte. X, Y and STATUS update on the
//   same edge, one cycle after the third byte is sampled.
// Ports:
//   CLK           in   1  system clock, rising edge
//   RESET_N       in   1  asynchronous active-low reset
//   ENABLE        in   1  stream mode active; low resyncs and ignores bytes
//   BYTE_IN       in   8  received byte, valid with BYTE_VALID
//   BYTE_VALID    in   1  one-cycle strobe per byte
//   MOUSE_X       out  8  cursor X, 0..X_MAX
//   MOUSE_Y       out  8  cursor Y, 0..Y_MAX, 0 at top
//   MOUSE_STATUS  out  8  byte 0 of the last committed packet
//   PACKET_DONE   out  1  one-cycle pulse when the outputs update
//   SYNC_ERR      out  1  one-cycle pulse when a byte or partial packet is dropped
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119,
    parameter int X_INIT       = 80,
    parameter int Y_INIT       = 60,
    parameter int SYNC_TIMEOUT = 2000000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic [7:0] MOUSE_STATUS,
    output logic       PACKET_DONE,
    output logic       SYNC_ERR
);

    localparam int              CNT_W    = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       b0_q, b1_q, b2_q;
    logic             commit_q;   // full packet captured; outputs load next edge
    logic             err_pend;   // SYNC_ERR deferred so it never overlaps PACKET_DONE
    logic [7:0]       next_x, next_y;

    mouse_axis_accum #(.INVERT(1'b0)) u_x_accum (
        .pos      (MOUSE_X),
        .delta    ({b0_q[BIT_XS], b1_q}),
        .ovf      (b0_q[BIT_XV]),
        .max_pos  (8'(X_MAX)),
        .next_pos (next_x)
    );

    mouse_axis_accum #(.INVERT(1'b1)) u_y_accum (
        .pos      (MOUSE_Y),
        .delta    ({b0_q[BIT_YS], b2_q}),
        .ovf      (b0_q[BIT_YV]),
        .max_pos  (8'(Y_MAX)),
        .next_pos (next_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= WAIT_B0;
            idle_cnt     <= '0;
            b0_q         <= 8'h00;
            b1_q         <= 8'h00;
            b2_q         <= 8'h00;
            commit_q     <= 1'b0;
            err_pend     <= 1'b0;
            MOUSE_X      <= 8'(X_INIT);
            MOUSE_Y      <= 8'(Y_INIT);
            MOUSE_STATUS <= 8'h00;
            PACKET_DONE  <= 1'b0;
            SYNC_ERR     <= 1'b0;
        end else begin
            PACKET_DONE <= 1'b0;
            SYNC_ERR    <= err_pend;
            err_pend    <= 1'b0;
            commit_q    <= 1'b0;

            // A packet captured on the previous edge always completes, even
            // if ENABLE has since dropped: it was already accepted.
            if (commit_q) begin
                MOUSE_X      <= next_x;
                MOUSE_Y      <= next_y;
                MOUSE_STATUS <= b0_q;
                PACKET_DONE  <= 1'b1;
            end

            if (!ENABLE) begin
                state    <= WAIT_B0;
                idle_cnt <= '0;
            end else if (BYTE_VALID) begin
                // A byte arriving on the expiry cycle wins over the timeout.
                idle_cnt <= '0;
                case (state)
                    WAIT_B0: begin
                        if (BYTE_IN[BIT_SYNC]) begin
                            b0_q  <= BYTE_IN;
                            state <= WAIT_B1;
                        end else if (commit_q) begin
                            err_pend <= 1'b1;
                        end else begin
                            SYNC_ERR <= 1'b1;
                        end
                    end
                    WAIT_B1: begin
                        b1_q  <= BYTE_IN;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        b2_q     <= BYTE_IN;
                        state    <= WAIT_B0;
                        commit_q <= 1'b1;
                    end
                    default: state <= WAIT_B0;
                endcase
            end else if (state != WAIT_B0) begin
                if (idle_cnt == CNT_LAST) begin
                    state    <= WAIT_B0;
                    idle_cnt <= '0;
                    SYNC_ERR <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb_mouse_packet_decoder
//   Directed and randomized packets checked against an arithmetic model of
//   the cursor (signed deltas, overflow masking, Y inversion, clamping).
module tb_mouse_packet_decoder;

    localparam int X_MAX   = 159;
    localparam int Y_MAX   = 119;
    localparam int X_INIT  = 80;
    localparam int Y_INIT  = 60;
    localparam int TIMEOUT = 40;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE = 1'b0;
    logic [7:0] BYTE_IN = 8'h00;
    logic       BYTE_VALID = 1'b0;
    logic [7:0] MOUSE_X, MOUSE_Y, MOUSE_STATUS;
    logic       PACKET_DONE, SYNC_ERR;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    // Reference cursor state
    int mx = X_INIT;
    int my = Y_INIT;
    int ms = 0;

    mouse_packet_decoder #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .SYNC_TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
        .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_STATUS(MOUSE_STATUS),
        .PACKET_DONE(PACKET_DONE), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Pulse monitor
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (SYNC_ERR)                err_cnt++;
            if (PACKET_DONE)             done_cnt++;
            if (SYNC_ERR && PACKET_DONE) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Model of one committed packet, straight from the packet format.
    function automatic void model_commit(input logic [7:0] b0, b1, b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = clamp(mx + dx, X_MAX);
        my = clamp(my - dy, Y_MAX);
        ms = int'(b0);
    endfunction

    task automatic drive(input logic [7:0] b, input logic v);
        @(negedge CLK);
        BYTE_IN    = b;
        BYTE_VALID = v;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, MOUSE_X, mx);
        check({tag, "_y"}, MOUSE_Y, my);
        check({tag, "_status"}, MOUSE_STATUS, ms);
    endtask

    // Back-to-back packet with latency checks around the commit edge.
    task automatic send_packet(input string tag, input logic [7:0] b0, b1, b2);
        drive(b0, 1'b1);
        drive(b1, 1'b1);
        drive(b2, 1'b1);
        drive(8'h00, 1'b0);          // edge N has sampled b2
        check({tag, "_done_early"}, PACKET_DONE, 1'b0);
        model_commit(b0, b1, b2);
        @(negedge CLK);              // after edge N+1
        check({tag, "_done"}, PACKET_DONE, 1'b1);
        check_pos(tag);
        @(negedge CLK);
        check({tag, "_done_width"}, PACKET_DONE, 1'b0);
    endtask

    task automatic do_reset;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        mx = X_INIT; my = Y_INIT; ms = 0;
        @(negedge CLK);
    endtask

    initial begin
        int e0, d0;
        logic [7:0] r0, r1, r2;

        // Reset state
        ENABLE = 1'b1;
        do_reset();
        check_pos("reset");
        check("reset_done", PACKET_DONE, 1'b0);
        check("reset_err", SYNC_ERR, 1'b0);

        // Basic packet: X 80+5, Y 60-3
        send_packet("basic", 8'h08, 8'h05, 8'h03);
        check("basic_x_abs", MOUSE_X, 85);

        // Clamp low on X, clamp high on Y
        do_reset();
        send_packet("clamp_x", 8'h18, 8'h9C, 8'h00);
        check("clamp_x_abs", MOUSE_X, 0);
        send_packet("clamp_y", 8'h28, 8'h00, 8'h80);
        check("clamp_y_abs", MOUSE_Y, Y_MAX);

        // Out-of-sync byte dropped, next packet decodes
        e0 = err_cnt;
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        repeat (2) @(negedge CLK);
        #1 check("bad_b0_err", err_cnt - e0, 1);
        send_packet("resync", 8'h09, 8'h00, 8'h00);

        // Timeout drops the partial packet
        e0 = err_cnt;
        d0 = done_cnt;
        drive(8'h08, 1'b1);
        drive(8'h05, 1'b1);
        drive(8'h00, 1'b0);
        for (int i = 0; i < TIMEOUT + 5 && err_cnt == e0; i++) @(negedge CLK);
        #1 check("timeout_err", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        send_packet("after_timeout", 8'h08, 8'h01, 8'h01);

        // Byte landing on the expiry cycle wins
        e0 = err_cnt;
        drive(8'h08, 1'b1);
        drive(8'h00, 1'b0);
        repeat (TIMEOUT - 2) @(negedge CLK);
        drive(8'h02, 1'b1);          // sampled on the expiry edge
        drive(8'h02, 1'b1);
        drive(8'h00, 1'b0);
        model_commit(8'h08, 8'h02, 8'h02);
        repeat (2) @(negedge CLK);
        #1 check("race_no_err", err_cnt - e0, 0);
        check_pos("race");

        // X overflow masks dx
        send_packet("xv", 8'h48, 8'hFF, 8'h01);

        // ENABLE low: bytes ignored, outputs held
        d0 = done_cnt;
        ENABLE = 1'b0;
        drive(8'h48, 1'b1);
        drive(8'hFF, 1'b1);
        drive(8'h01, 1'b1);
        drive(8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        #1 check("disabled_done", done_cnt - d0, 0);
        check_pos("disabled");

        // ENABLE low mid-packet forces resync
        ENABLE = 1'b1;
        drive(8'h08, 1'b1);
        drive(8'h05, 1'b1);
        drive(8'h00, 1'b0);
        ENABLE = 1'b0;
        @(negedge CLK);
        ENABLE = 1'b1;
        send_packet("enable_resync", 8'h08, 8'h03, 8'h04);

        // Two packets back-to-back, then a bad byte right after a commit
        e0 = err_cnt;
        d0 = done_cnt;
        drive(8'h08, 1'b1); drive(8'h01, 1'b1); drive(8'h01, 1'b1);
        drive(8'h09, 1'b1); drive(8'h02, 1'b1); drive(8'h02, 1'b1);
        drive(8'h00, 1'b1);          // bad byte 0 on the commit cycle
        drive(8'h00, 1'b0);
        model_commit(8'h08, 8'h01, 8'h01);
        model_commit(8'h09, 8'h02, 8'h02);
        repeat (4) @(negedge CLK);
        #1 check("b2b_done", done_cnt - d0, 2);
        check("b2b_err", err_cnt - e0, 1);
        check_pos("b2b");

        // Asynchronous reset mid-packet
        drive(8'h08, 1'b1);
        drive(8'h30, 1'b1);
        drive(8'h00, 1'b0);
        #2 RESET_N = 1'b0;
        #1 check("async_rst_x", MOUSE_X, X_INIT);
        check("async_rst_y", MOUSE_Y, Y_INIT);
        @(negedge CLK);
        RESET_N = 1'b1;
        mx = X_INIT; my = Y_INIT; ms = 0;
        @(negedge CLK);
        send_packet("after_rst", 8'h08, 8'h01, 8'h00);

        // Randomized packets
        for (int i = 0; i < 40; i++) begin
            r0 = 8'($urandom_range(0, 255)) | 8'h08;
            r1 = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            r2 = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            send_packet("rand", r0, r1, r2);
        end

        check("pulse_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
